shift_seq_ctrl: RTL

- Sequencing controller for the team's WIDTH-stage serial shift chain.
- Runs one transaction per start request:
  - transmit: parallel-load a word, then shift it out serially, MSB first;
  - receive: shift WIDTH serial bits in, then present them as a parallel word.
- Provides the start/busy/done handshake and bit counting that the bare shift chain lacks. Sits between a host FSM and the serial line.

---
 rtl/shift_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Start/busy/done sequencer for a WIDTH-stage serial shift chain: MSB-first transmit or receive.
// Define SHIFT_SEQ_CTRL_PARITY_EN to append an even-parity bit (PAR state) to every transaction.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] din_par,
  input  logic             sin,
  output logic             sout,
  output logic             sout_valid,
  output logic [WIDTH-1:0] dout_par,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             par_err
);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shnext;
  logic [CNT_W-1:0] cnt;
  logic             mode_r;

  // One chain serves both directions: transmit shifts in zeros, receive shifts in sin.
  always_comb begin
    shnext = {shreg[WIDTH-2:0], (mode_r ? 1'b0 : sin)};
  end

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic par_tx;
  logic par_err_r;
  assign par_err = par_err_r;
`else
  assign par_err = 1'b0;
`endif

  // Outputs are registered: each transition loads the values the next state decodes to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      mode_r     <= 1'b0;
      dout_par   <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      par_tx     <= 1'b0;
      par_err_r  <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      dout_valid <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SHIFT;
            mode_r     <= mode;
            cnt        <= '0;
            shreg      <= mode ? din_par : '0;
            busy       <= 1'b1;
            sout       <= mode & din_par[WIDTH-1];
            sout_valid <= mode;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            par_tx     <= ^din_par;
`endif
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            shreg <= shnext;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
              state      <= PAR;
              sout       <= mode_r & par_tx;
              sout_valid <= mode_r;
`else
              state <= DONE;
              done  <= 1'b1;
              if (!mode_r) begin
                dout_par   <= shnext;
                dout_valid <= 1'b1;
              end
`endif
            end else begin
              sout       <= mode_r & shnext[WIDTH-1];
              sout_valid <= mode_r;
            end
          end
        end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        PAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            if (!mode_r) begin
              dout_par   <= shreg;
              dout_valid <= 1'b1;
              par_err_r  <= (^shreg) ^ sin;
            end
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
